insn_fetch: RTL and testbench

Instruction fetch stage: owns the program counter and issues word reads to a synchronous instruction memory. It buffers the returned instructions in a 2-entry queue and presents them to the instruction decoder with a valid/stall handshake. It sits directly upstream of the decoder: `valid_o`/`insn_o` feed the decoder's `valid_i`/`insn`, and the decoder's stall feeds `stall_i`. Branch/jump redirects from execute enter through `redirect_i`.

---
 rtl/insn_fetch.sv | 121 ++++++++++++
 tb/tb_insn_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
`default_nettype none
// ============================================================================
// Module   : insn_fetch
// Purpose  : Instruction fetch stage. Owns the program counter, issues word
//            reads to a synchronous instruction memory, buffers returned
//            words in a 2-entry queue and hands them to the decoder with a
//            valid/stall handshake. A redirect flushes everything and
//            restarts fetch at the supplied target.
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            stall_i             - decoder cannot accept this cycle
//            valid_o/insn_o/pc_o - queue head presented to the decoder
//            redirect_i/_pc_i    - flush and restart fetch at target
//            imem_en_o/addr_o    - memory read request (combinational enable)
//            imem_data_i         - read data, one cycle after request edge
// Revision : 1.0 - initial release
// ============================================================================
module insn_fetch #(
    parameter int                LEN_INSN = 32,
    parameter int                LEN_PC   = 16,
    parameter logic [LEN_PC-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    output logic                valid_o,
    output logic [LEN_INSN-1:0] insn_o,
    output logic [LEN_PC-1:0]   pc_o,
    input  logic                redirect_i,
    input  logic [LEN_PC-1:0]   redirect_pc_i,
    output logic                imem_en_o,
    output logic [LEN_PC-1:0]   imem_addr_o,
    input  logic [LEN_INSN-1:0] imem_data_i
);

    logic [LEN_PC-1:0]   fetch_pc;
    logic [LEN_PC-1:0]   inflight_pc;
    logic                inflight;
    logic [1:0]          occ;

    // Queue storage: slot 0 is always the head, slot 1 the entry behind it.
    logic [LEN_INSN-1:0] head_insn, tail_insn;
    logic [LEN_PC-1:0]   head_pc,   tail_pc;

    logic                pop;
    logic                issue;
    logic [1:0]          pending;
    logic [1:0]          occ_after_pop;
    logic [1:0]          next_occ;
    logic [LEN_INSN-1:0] next_head_insn, next_tail_insn;
    logic [LEN_PC-1:0]   next_head_pc,   next_tail_pc;

    assign valid_o     = (occ != 2'd0);
    assign pop         = valid_o & ~stall_i;
    assign insn_o      = head_insn;
    assign pc_o        = head_pc;
    assign imem_addr_o = fetch_pc;

    // Slots that will be claimed after this edge. occ + inflight never
    // exceeds 2 and pop implies occ >= 1, so this stays within 0..2.
    assign pending   = occ + 2'(inflight) - 2'(pop);
    assign issue     = ~rst & ~redirect_i & (pending < 2'd2);
    assign imem_en_o = issue;

    always_comb begin
        next_head_insn = head_insn;
        next_head_pc   = head_pc;
        next_tail_insn = tail_insn;
        next_tail_pc   = tail_pc;
        occ_after_pop  = occ - 2'(pop);

        if (pop) begin
            next_head_insn = tail_insn;
            next_head_pc   = tail_pc;
        end

        // The returning word lands in the first free slot after the pop.
        if (inflight) begin
            if (occ_after_pop == 2'd0) begin
                next_head_insn = imem_data_i;
                next_head_pc   = inflight_pc;
            end else begin
                next_tail_insn = imem_data_i;
                next_tail_pc   = inflight_pc;
            end
        end

        next_occ = occ_after_pop + 2'(inflight);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            occ         <= 2'd0;
            head_insn   <= '0;
            head_pc     <= '0;
            tail_insn   <= '0;
            tail_pc     <= '0;
        end else if (redirect_i) begin
            // No request is issued in a redirect cycle, so once the current
            // response is dropped here nothing stale can follow.
            fetch_pc <= redirect_pc_i;
            inflight <= 1'b0;
            occ      <= 2'd0;
        end else begin
            head_insn <= next_head_insn;
            head_pc   <= next_head_pc;
            tail_insn <= next_tail_insn;
            tail_pc   <= next_tail_pc;
            occ       <= next_occ;
            inflight  <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_insn_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_fetch
// Purpose  : Directed bench for insn_fetch. Main instance uses the default
//            16-bit PC with memory word i = 0x100 + i; a second instance uses
//            a 4-bit PC starting at 14 with word i = 0x200 + i.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic        valid_o;
    logic [31:0] insn_o;
    logic [15:0] pc_o;
    logic        imem_en_o;
    logic [15:0] imem_addr_o;
    logic [31:0] imem_data_i = '0;

    logic        rst_w = 1'b0;
    logic        valid_w;
    logic [31:0] insn_w;
    logic [3:0]  pc_w;
    logic        en_w;
    logic [3:0]  addr_w;
    logic [31:0] data_w = '0;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    insn_fetch #(.LEN_INSN(32), .LEN_PC(16), .RESET_PC(16'd0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .valid_o(valid_o), .insn_o(insn_o), .pc_o(pc_o),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_en_o(imem_en_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i)
    );

    insn_fetch #(.LEN_INSN(32), .LEN_PC(4), .RESET_PC(4'd14)) dut_wrap (
        .clk(clk), .rst(rst_w), .stall_i(1'b0),
        .valid_o(valid_w), .insn_o(insn_w), .pc_o(pc_w),
        .redirect_i(1'b0), .redirect_pc_i(4'd0),
        .imem_en_o(en_w), .imem_addr_o(addr_w), .imem_data_i(data_w)
    );

    // Synchronous instruction memories
    always @(posedge clk) begin
        if (imem_en_o) imem_data_i <= 32'h100 + {16'd0, imem_addr_o};
        if (en_w)      data_w      <= 32'h200 + {28'd0, addr_w};
    end

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #2;
        total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else pass_cnt++;
        total++; if (imem_en_o !== 1'b0) $display("FAIL reset_en: got %b want 0", imem_en_o); else pass_cnt++;
        total++; if (imem_addr_o !== 16'h0) $display("FAIL reset_addr: got %h want 0", imem_addr_o); else pass_cnt++;
        total++; if ({insn_o, pc_o} !== 48'h0) $display("FAIL reset_out: got %h/%h want 0/0", insn_o, pc_o); else pass_cnt++;
    endtask

    task automatic test_startup();
        @(posedge clk); #1 rst = 1'b0; #1;
        total++; if ({imem_en_o, imem_addr_o, valid_o} !== {1'b1, 16'h0, 1'b0})
            $display("FAIL start_c0: got en=%b addr=%h v=%b want en=1 addr=0 v=0", imem_en_o, imem_addr_o, valid_o); else pass_cnt++;
        @(posedge clk); #2;
        total++; if ({imem_en_o, imem_addr_o, valid_o} !== {1'b1, 16'h1, 1'b0})
            $display("FAIL start_c1: got en=%b addr=%h v=%b want en=1 addr=1 v=0", imem_en_o, imem_addr_o, valid_o); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            total++; if ({valid_o, pc_o, insn_o, imem_en_o} !== {1'b1, 16'(k), 32'h100 + 32'(k), 1'b1})
                $display("FAIL start_stream%0d: got v=%b pc=%h insn=%h en=%b want v=1 pc=%h insn=%h en=1",
                         k, valid_o, pc_o, insn_o, imem_en_o, k, 32'h100 + 32'(k)); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        int n = 0;
        while (!(valid_o === 1'b1 && pc_o === 16'd5) && n < 20) begin
            @(posedge clk); #2; n++;
        end
        total++; if (n >= 20) $display("FAIL stall_reach_pc5: got pc=%h want 0005", pc_o); else pass_cnt++;
        stall_i = 1'b1; #1;
        total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'd5, 32'h105})
            $display("FAIL stall_s: got v=%b pc=%h insn=%h want v=1 pc=5 insn=105", valid_o, pc_o, insn_o); else pass_cnt++;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #2;
            total++; if ({valid_o, pc_o, insn_o, imem_en_o} !== {1'b1, 16'd5, 32'h105, 1'b0})
                $display("FAIL stall_hold%0d: got v=%b pc=%h insn=%h en=%b want v=1 pc=5 insn=105 en=0",
                         k, valid_o, pc_o, insn_o, imem_en_o); else pass_cnt++;
        end
        @(posedge clk); #1 stall_i = 1'b0; #1;
        total++; if ({valid_o, pc_o, imem_en_o} !== {1'b1, 16'd5, 1'b1})
            $display("FAIL stall_release: got v=%b pc=%h en=%b want v=1 pc=5 en=1", valid_o, pc_o, imem_en_o); else pass_cnt++;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #2;
            total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'd5 + 16'(k), 32'h105 + 32'(k)})
                $display("FAIL stall_after%0d: got v=%b pc=%h insn=%h want v=1 pc=%h insn=%h",
                         k, valid_o, pc_o, insn_o, 5 + k, 32'h105 + 32'(k)); else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        @(posedge clk); #1 redirect_i = 1'b1; redirect_pc_i = 16'h40; #1;
        total++; if (imem_en_o !== 1'b0) $display("FAIL redir_en_t: got %b want 0", imem_en_o); else pass_cnt++;
        @(posedge clk); #1 redirect_i = 1'b0; #1;
        total++; if ({valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 16'h40})
            $display("FAIL redir_t1: got v=%b en=%b addr=%h want v=0 en=1 addr=0040", valid_o, imem_en_o, imem_addr_o); else pass_cnt++;
        @(posedge clk); #2;
        total++; if (valid_o !== 1'b0) $display("FAIL redir_t2_valid: got %b want 0", valid_o); else pass_cnt++;
        @(posedge clk); #2;
        total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'h40, 32'h140})
            $display("FAIL redir_t3: got v=%b pc=%h insn=%h want v=1 pc=0040 insn=140", valid_o, pc_o, insn_o); else pass_cnt++;
        @(posedge clk); #2;
        total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'h41, 32'h141})
            $display("FAIL redir_t4: got v=%b pc=%h insn=%h want v=1 pc=0041 insn=141", valid_o, pc_o, insn_o); else pass_cnt++;
    endtask

    task automatic test_redirect_stall();
        @(posedge clk); #1 stall_i = 1'b1;
        @(posedge clk); #2;
        total++; if ({valid_o, imem_en_o} !== {1'b1, 1'b0})
            $display("FAIL rstall_full: got v=%b en=%b want v=1 en=0", valid_o, imem_en_o); else pass_cnt++;
        @(posedge clk); #1 redirect_i = 1'b1; redirect_pc_i = 16'h80; #1;
        total++; if (imem_en_o !== 1'b0) $display("FAIL rstall_en_t: got %b want 0", imem_en_o); else pass_cnt++;
        @(posedge clk); #1 redirect_i = 1'b0; #1;
        total++; if ({valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 16'h80})
            $display("FAIL rstall_t1: got v=%b en=%b addr=%h want v=0 en=1 addr=0080", valid_o, imem_en_o, imem_addr_o); else pass_cnt++;
        @(posedge clk); #2;
        total++; if (valid_o !== 1'b0) $display("FAIL rstall_t2_valid: got %b want 0", valid_o); else pass_cnt++;
        for (int k = 3; k <= 4; k++) begin
            @(posedge clk); #2;
            total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'h80, 32'h180})
                $display("FAIL rstall_t%0d: got v=%b pc=%h insn=%h want v=1 pc=0080 insn=180", k, valid_o, pc_o, insn_o); else pass_cnt++;
        end
        // Back-to-back redirects: the second target wins
        @(posedge clk); #1 stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 16'h10; #1;
        total++; if (imem_en_o !== 1'b0) $display("FAIL b2b_en_t: got %b want 0", imem_en_o); else pass_cnt++;
        @(posedge clk); #1 redirect_pc_i = 16'h20; #1;
        total++; if ({imem_en_o, valid_o} !== 2'b00) $display("FAIL b2b_t1: got en=%b v=%b want 0 0", imem_en_o, valid_o); else pass_cnt++;
        @(posedge clk); #1 redirect_i = 1'b0; #1;
        total++; if ({valid_o, imem_en_o, imem_addr_o} !== {1'b0, 1'b1, 16'h20})
            $display("FAIL b2b_t2: got v=%b en=%b addr=%h want v=0 en=1 addr=0020", valid_o, imem_en_o, imem_addr_o); else pass_cnt++;
        @(posedge clk); #2;
        @(posedge clk); #2;
        total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'h20, 32'h120})
            $display("FAIL b2b_out: got v=%b pc=%h insn=%h want v=1 pc=0020 insn=120", valid_o, pc_o, insn_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 stall_i = 1'b1;
        @(posedge clk); #2;
        total++; if ({valid_o, imem_en_o} !== {1'b1, 1'b0})
            $display("FAIL rmid_full: got v=%b en=%b want v=1 en=0", valid_o, imem_en_o); else pass_cnt++;
        #1 rst = 1'b1; #1;
        total++; if ({valid_o, imem_en_o, imem_addr_o, pc_o, insn_o} !== {1'b0, 1'b0, 16'h0, 16'h0, 32'h0})
            $display("FAIL rmid_async: got v=%b en=%b addr=%h pc=%h insn=%h want all 0",
                     valid_o, imem_en_o, imem_addr_o, pc_o, insn_o); else pass_cnt++;
        stall_i = 1'b0;
        @(posedge clk); #2;
        total++; if (valid_o !== 1'b0) $display("FAIL rmid_held: got v=%b want 0", valid_o); else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0; #1;
        total++; if ({imem_en_o, imem_addr_o, valid_o} !== {1'b1, 16'h0, 1'b0})
            $display("FAIL rmid_c0: got en=%b addr=%h v=%b want en=1 addr=0 v=0", imem_en_o, imem_addr_o, valid_o); else pass_cnt++;
        @(posedge clk); #2;
        total++; if (valid_o !== 1'b0) $display("FAIL rmid_c1: got v=%b want 0", valid_o); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            total++; if ({valid_o, pc_o, insn_o} !== {1'b1, 16'(k), 32'h100 + 32'(k)})
                $display("FAIL rmid_stream%0d: got v=%b pc=%h insn=%h want v=1 pc=%h insn=%h",
                         k, valid_o, pc_o, insn_o, k, 32'h100 + 32'(k)); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  exp_pc [4];
        logic [31:0] exp_insn [4];
        exp_pc   = '{4'd14, 4'd15, 4'd0, 4'd1};
        exp_insn = '{32'h20E, 32'h20F, 32'h200, 32'h201};
        @(posedge clk); #1 rst_w = 1'b0; #1;
        total++; if ({en_w, addr_w} !== {1'b1, 4'd14})
            $display("FAIL wrap_c0: got en=%b addr=%h want en=1 addr=e", en_w, addr_w); else pass_cnt++;
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            total++; if ({valid_w, pc_w, insn_w} !== {1'b1, exp_pc[k], exp_insn[k]})
                $display("FAIL wrap_seq%0d: got v=%b pc=%h insn=%h want v=1 pc=%h insn=%h",
                         k, valid_w, pc_w, insn_w, exp_pc[k], exp_insn[k]); else pass_cnt++;
        end
    endtask

    initial begin
        #2 rst = 1'b1; rst_w = 1'b1;
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
